// File: rtl/sweep_pkg.sv
// sweep_pkg -- shared types and constants for the exhaustive sweep checker.
//   sweep_state_t : sweep FSM states (IDLE / DRIVE / DONE)
//   SIG_W         : signature width of the optional response MISR
//   MISR_POLY     : MISR feedback polynomial x^16+x^12+x^5+1 (x^16 implied)
//   MISR_SEED     : MISR value after reset and after every accepted start
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int                SIG_W     = 16;
    localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;
    localparam logic [SIG_W-1:0]  MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/sweep_misr.sv
// sweep_misr -- 16-bit serial-input MISR compacting the sampled DUT responses.
// Each enabled clock the register shifts left by one; the bit leaving the MSB,
// XORed with din, is folded back through MISR_POLY.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, loads MISR_SEED
//   clr  : synchronous reseed to MISR_SEED (has priority over en)
//   en   : shift din into the signature this clock
//   din  : serial response bit
//   sig  : current signature
module sweep_misr
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_reg;
    logic [SIG_W-1:0] sig_next;
    logic [SIG_W-1:0] shifted;
    logic             feedback;

    assign feedback = sig_reg[SIG_W-1] ^ din;

    // One XOR tap per bit: bit gi takes its lower neighbour (zero for bit 0)
    // and, where the polynomial has a term, the feedback bit.
    genvar gi;
    generate
        for (gi = 0; gi < SIG_W; gi++) begin : g_misr_bit
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = feedback & MISR_POLY[gi];
            end else begin : g_upper
                assign shifted[gi] = sig_reg[gi-1] ^ (feedback & MISR_POLY[gi]);
            end
        end
    endgenerate

    always_comb begin
        sig_next = sig_reg;
        if (clr) begin
            sig_next = MISR_SEED;
        end else if (en) begin
            sig_next = shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_reg <= MISR_SEED;
        end else begin
            sig_reg <= sig_next;
        end
    end

    assign sig = sig_reg;

endmodule

// File: rtl/sweep_checker.sv
// sweep_checker -- exhaustive stimulus engine and response checker for a
// small combinational block with N_IN inputs and one output.
// On an accepted start it walks vec through 0 .. 2**N_IN-1, holding each
// value for HOLD clocks, samples f_in on the last clock of every hold window
// and compares it with EXP_MASK[vec].
// Optional feature macro: SWEEP_MISR_EN -- adds the 16-bit 'sig' output, a
// MISR signature of every sampled f_in bit.
// Ports:
//   clk           : rising-edge clock
//   rst           : asynchronous active-high reset
//   start         : begin a sweep; honoured only in IDLE or DONE
//   vec           : vector driven to the DUT inputs (MSB = first DUT input)
//   vec_valid     : vec is being driven (DRIVE state)
//   f_in          : DUT response
//   busy          : sweep in progress
//   done          : sweep complete, sticky until next accepted start or rst
//   pass          : done with zero mismatches
//   err_cnt       : number of mismatching vectors, 0 .. 2**N_IN
//   first_err_idx : index of the first mismatching vector
//   first_err_vld : first_err_idx holds a real mismatch
//   sig           : (SWEEP_MISR_EN only) response signature
module sweep_checker
    import sweep_pkg::*;
#(
    parameter int                N_IN     = 4,
    parameter int                HOLD     = 10,
    parameter logic [2**N_IN-1:0] EXP_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec,
    output logic              vec_valid,
    input  logic              f_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_err_idx,
    output logic              first_err_vld
`ifdef SWEEP_MISR_EN
    ,
    output logic [SIG_W-1:0]  sig
`endif
);

    // A one-clock hold window still needs a (constant zero) counter bit.
    localparam int                 HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_IN-1:0]    VEC_LAST  = '1;
    localparam logic [N_IN-1:0]    VEC_ONE   = N_IN'(1);
    localparam logic [N_IN:0]      ERR_ONE   = (N_IN + 1)'(1);

    sweep_state_t        state_reg, state_next;
    logic [N_IN-1:0]     vec_reg, vec_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [N_IN:0]       err_cnt_reg, err_cnt_next;
    logic [N_IN-1:0]     first_err_idx_reg, first_err_idx_next;
    logic                first_err_vld_reg, first_err_vld_next;

    logic                accept;
    logic                sample;
    logic                mismatch;

    // start is ignored while a sweep is running
    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign sample   = (state_reg == DRIVE) && (hold_reg == HOLD_LAST);
    assign mismatch = sample && (f_in != EXP_MASK[vec_reg]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   if (sample && (vec_reg == VEC_LAST)) state_next = DONE;
            DONE:    if (start) state_next = DRIVE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state_reg == DRIVE);
        vec_valid = (state_reg == DRIVE);
        done      = (state_reg == DONE);
        pass      = (state_reg == DONE) && (err_cnt_reg == '0);
    end

    // ---------------- datapath: vector / hold / error bookkeeping ----------------
    always_comb begin
        vec_next           = vec_reg;
        hold_next          = hold_reg;
        err_cnt_next       = err_cnt_reg;
        first_err_idx_next = first_err_idx_reg;
        first_err_vld_next = first_err_vld_reg;

        if (accept) begin
            vec_next           = '0;
            hold_next          = '0;
            err_cnt_next       = '0;
            first_err_idx_next = '0;
            first_err_vld_next = 1'b0;
        end else if (state_reg == DRIVE) begin
            if (sample) begin
                // err_cnt is one bit wider than vec, so 2**N_IN failures fit
                if (mismatch) begin
                    err_cnt_next = err_cnt_reg + ERR_ONE;
                    if (!first_err_vld_reg) begin
                        first_err_idx_next = vec_reg;
                        first_err_vld_next = 1'b1;
                    end
                end
                hold_next = '0;
                // the last vector stays on vec after the sweep ends
                if (vec_reg != VEC_LAST) begin
                    vec_next = vec_reg + VEC_ONE;
                end
            end else begin
                hold_next = hold_reg + HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_reg           <= '0;
            hold_reg          <= '0;
            err_cnt_reg       <= '0;
            first_err_idx_reg <= '0;
            first_err_vld_reg <= 1'b0;
        end else begin
            vec_reg           <= vec_next;
            hold_reg          <= hold_next;
            err_cnt_reg       <= err_cnt_next;
            first_err_idx_reg <= first_err_idx_next;
            first_err_vld_reg <= first_err_vld_next;
        end
    end

    assign vec           = vec_reg;
    assign err_cnt       = err_cnt_reg;
    assign first_err_idx = first_err_idx_reg;
    assign first_err_vld = first_err_vld_reg;

`ifdef SWEEP_MISR_EN
    // Only sample clocks advance the signature, so it is frozen in IDLE/DONE.
    sweep_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (sample),
        .din (f_in),
        .sig (sig)
    );
`endif

endmodule

// File: tb/tb_sweep_checker.sv
// tb_sweep_checker -- self-checking bench for sweep_checker.
// dut    : N_IN=4, HOLD=10, EXP_MASK=16'hA5C3, driven by a behavioural lab-DUT model
//          that can be made correct, single-faulty (vec 5), all-wrong or glitchy.
// dut_h1 : same mask with HOLD=1 for the latency check.
// Expected end-of-sweep results and the expected vector sequence are pushed
// into queues when a sweep is launched and popped when the DUT produces them.
module tb_sweep_checker;

    localparam int TB_HOLD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0;
    logic [3:0]  vec;
    logic        vec_valid;
    logic        f_in;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err_idx;
    logic        first_err_vld;

    logic        start1 = 1'b0;
    logic [3:0]  vec1;
    logic        vec_valid1;
    logic        f_in1;
    logic        busy1, done1, pass1;
    logic [4:0]  err_cnt1;
    logic [3:0]  first_err_idx1;
    logic        first_err_vld1;

`ifdef SWEEP_MISR_EN
    logic [15:0] sig;
    logic [15:0] sig1;
`endif

    logic [15:0] exp_mask_v = 16'hA5C3;
    int          fault_mode = 0;   // 0 correct, 1 invert at vec 5, 2 invert everywhere
    bit          glitch_en  = 1'b0;
    int          tb_hold    = 0;   // bench's own position inside the hold window

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          err;
        int          idx;
        bit          vld;
        bit          pass;
        logic [15:0] sig;
    } exp_t;

    exp_t        res_q[$];
    logic [3:0]  vec_q[$];

    sweep_checker #(.N_IN(4), .HOLD(TB_HOLD), .EXP_MASK(16'hA5C3)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vec           (vec),
        .vec_valid     (vec_valid),
        .f_in          (f_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
`ifdef SWEEP_MISR_EN
        ,
        .sig           (sig)
`endif
    );

    sweep_checker #(.N_IN(4), .HOLD(1), .EXP_MASK(16'hA5C3)) dut_h1 (
        .clk           (clk),
        .rst           (rst),
        .start         (start1),
        .vec           (vec1),
        .vec_valid     (vec_valid1),
        .f_in          (f_in1),
        .busy          (busy1),
        .done          (done1),
        .pass          (pass1),
        .err_cnt       (err_cnt1),
        .first_err_idx (first_err_idx1),
        .first_err_vld (first_err_vld1)
`ifdef SWEEP_MISR_EN
        ,
        .sig           (sig1)
`endif
    );

    always #5 clk = ~clk;

    // Lab-DUT model; glitches corrupt every clock of the window except the last.
    always_comb begin
        f_in = exp_mask_v[vec];
        if (fault_mode == 1 && vec == 4'd5) f_in = ~f_in;
        if (fault_mode == 2)                f_in = ~f_in;
        if (glitch_en && tb_hold != TB_HOLD - 1) f_in = ~f_in;
    end

    always_comb begin
        f_in1 = exp_mask_v[vec1];
    end

    always @(posedge clk or posedge rst) begin
        if (rst)                                      tb_hold <= 0;
        else if (vec_valid && tb_hold != TB_HOLD - 1) tb_hold <= tb_hold + 1;
        else                                          tb_hold <= 0;
    end

    // Vector-sequence scoreboard: one pop per sample window of dut.
    always @(negedge clk) begin
        if (!rst && vec_valid && tb_hold == TB_HOLD - 1) begin
            checks++;
            if (vec_q.size() == 0) begin
                errors++;
                $display("FAIL vec_seq: sampled vec %0d, required no sample", vec);
            end else begin
                logic [3:0] ev;
                ev = vec_q.pop_front();
                if (vec !== ev) begin
                    errors++;
                    $display("FAIL vec_seq: got %0d required %0d", vec, ev);
                end
            end
        end
    end

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic d);
        logic fb;
        fb = s[15] ^ d;
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Launch one sweep on dut, check it and compare its final result.
    task automatic run_sweep(input string name, input int mode, input bit glitch, input bit mid_start);
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          busy_cyc;
        logic [15:0] s;
        logic [15:0] s_clean;
        bit          fbit;

        e.err = 0; e.idx = 0; e.vld = 1'b0;
        s = 16'hFFFF; s_clean = 16'hFFFF;
        for (int v = 0; v < 16; v++) begin
            fbit = exp_mask_v[v] ^ (mode == 1 && v == 5) ^ (mode == 2);
            if (fbit != exp_mask_v[v]) begin
                if (!e.vld) begin e.idx = v; e.vld = 1'b1; end
                e.err++;
            end
            s       = misr_ref(s, fbit);
            s_clean = misr_ref(s_clean, exp_mask_v[v]);
            vec_q.push_back(4'(v));
        end
        e.pass = (e.err == 0);
        e.sig  = s;
        res_q.push_back(e);

        fault_mode = mode;
        glitch_en  = glitch;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;

        // one clock after the start edge: counters cleared, sweep running
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || vec !== 4'd0 || err_cnt !== 5'd0 || first_err_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s start_clear: busy=%0b done=%0b vec=%0d err_cnt=%0d vld=%0b required 1 0 0 0 0",
                     name, busy, done, vec, err_cnt, first_err_vld);
        end

        cyc = 0; busy_cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            if (busy === 1'b1) busy_cyc++;
            start = (mid_start && cyc == 50);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        checks++;
        if (cyc != 16 * TB_HOLD || busy_cyc != 16 * TB_HOLD) begin
            errors++;
            $display("FAIL %s drive_len: done after %0d clocks, busy %0d clocks, required %0d",
                     name, cyc, busy_cyc, 16 * TB_HOLD);
        end

        got = res_q.pop_front();
        checks++;
        if (err_cnt !== 5'(got.err) || first_err_idx !== 4'(got.idx) || first_err_vld !== got.vld || pass !== got.pass) begin
            errors++;
            $display("FAIL %s result: err_cnt=%0d idx=%0d vld=%0b pass=%0b required %0d %0d %0b %0b",
                     name, err_cnt, first_err_idx, first_err_vld, pass, got.err, got.idx, got.vld, got.pass);
        end
        checks++;
        if (busy !== 1'b0 || vec_valid !== 1'b0 || vec !== 4'hF || done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_state: busy=%0b vec_valid=%0b vec=%0d done=%0b required 0 0 15 1",
                     name, busy, vec_valid, vec, done);
        end
        checks++;
        if (vec_q.size() != 0) begin
            errors++;
            $display("FAIL %s vec_count: %0d vectors never sampled, required 0", name, vec_q.size());
            vec_q.delete();
        end
`ifdef SWEEP_MISR_EN
        checks++;
        if (sig !== got.sig) begin
            errors++;
            $display("FAIL %s sig: got %h required %h", name, sig, got.sig);
        end
        if (mode != 0) begin
            checks++;
            if (sig === s_clean) begin
                errors++;
                $display("FAIL %s sig_fault: got %h required anything but %h", name, sig, s_clean);
            end
        end
        // signature must stay frozen while idling in DONE
        repeat (3) @(negedge clk);
        checks++;
        if (sig !== got.sig) begin
            errors++;
            $display("FAIL %s sig_frozen: got %h required %h", name, sig, got.sig);
        end
`endif
        $display("sweep %s: err_cnt=%0d first_err_idx=%0d vld=%0b pass=%0b clocks=%0d",
                 name, err_cnt, first_err_idx, first_err_vld, pass, cyc);
        glitch_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;   // before the first rising edge: reset must act asynchronously
        checks++;
        if (vec !== 4'd0 || vec_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_cnt !== 5'd0 || first_err_idx !== 4'd0 || first_err_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: vec=%0d vv=%0b busy=%0b done=%0b pass=%0b err=%0d idx=%0d vld=%0b required all 0",
                     vec, vec_valid, busy, done, pass, err_cnt, first_err_idx, first_err_vld);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || vec1 !== 4'd0 || err_cnt1 !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: busy=%0b done=%0b busy1=%0b done1=%0b vec1=%0d err1=%0d required all 0",
                     busy, done, busy1, done1, vec1, err_cnt1);
        end
`ifdef SWEEP_MISR_EN
        checks++;
        if (sig !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_sig: got %h required ffff", sig);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: busy=%0b done=%0b required 0 0", busy, done);
        end
        $display("reset: outputs cleared");
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        fault_mode = 2;
        glitch_en  = 1'b0;
        for (int v = 0; v < 16; v++) vec_q.push_back(4'(v));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (vec !== 4'd7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (vec !== 4'd7 || err_cnt !== 5'd7) begin
            errors++;
            $display("FAIL mid_pre: vec=%0d err_cnt=%0d required 7 7", vec, err_cnt);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (vec !== 4'd0 || vec_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_cnt !== 5'd0 || first_err_idx !== 4'd0 || first_err_vld !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: vec=%0d vv=%0b busy=%0b done=%0b pass=%0b err=%0d idx=%0d vld=%0b required all 0",
                     vec, vec_valid, busy, done, pass, err_cnt, first_err_idx, first_err_vld);
        end
        vec_q.delete();
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: busy=%0b done=%0b vec_valid=%0b required 0 0 0", busy, done, vec_valid);
        end
        $display("reset mid-sweep at vec 7: outputs cleared, idle");
    endtask

    task automatic test_hold1_latency();
        int cyc;
        int busy_cyc;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cyc = 0; busy_cyc = 0;
        while (done1 !== 1'b1 && cyc < 100) begin
            if (busy1 === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        // counting the start-sampling edge as clock 1, done rises on clock 17
        checks++;
        if (cyc + 1 != 17 || busy_cyc != 16) begin
            errors++;
            $display("FAIL hold1_latency: done on clock %0d busy %0d clocks, required 17 and 16", cyc + 1, busy_cyc);
        end
        checks++;
        if (pass1 !== 1'b1 || err_cnt1 !== 5'd0 || first_err_vld1 !== 1'b0 || vec1 !== 4'hF) begin
            errors++;
            $display("FAIL hold1_result: pass=%0b err=%0d vld=%0b vec=%0d required 1 0 0 15",
                     pass1, err_cnt1, first_err_vld1, vec1);
        end
        $display("hold1: done on clock %0d pass=%0b", cyc + 1, pass1);
    endtask

    initial begin
        test_reset();
        run_sweep("correct_glitchy", 0, 1'b1, 1'b0);
        run_sweep("single_fault",    1, 1'b0, 1'b0);
        run_sweep("all_wrong",       2, 1'b0, 1'b0);
        run_sweep("restart_in_done", 0, 1'b0, 1'b0);
        run_sweep("start_in_drive",  1, 1'b0, 1'b1);
        test_reset_mid_sweep();
        run_sweep("after_reset",     0, 1'b0, 1'b0);
        test_hold1_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
